systolic_feeder: RTL and testbench

//  Upstream sequencer for the NxN MAC-unit array. Accepts K operand beats via

---
 rtl/tpu_pkg.sv | 23 ++
 rtl/lane_delay.sv | 38 +++
 rtl/systolic_feeder.sv | 167 ++++++++++++++++
 tb/tb_systolic_feeder.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// ---------------------------------------------------------------------------
// tpu_pkg
// Shared definitions for the systolic-array front end: the feeder FSM state
// encoding, the PE state broadcast codes understood by the MAC units, and
// the default operand width.
// ---------------------------------------------------------------------------
package tpu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FEED  = 3'd1,
    DRAIN = 3'd2,
    WAIT  = 3'd3,
    CLEAR = 3'd4
  } fsm_t;

  // MAC units accumulate on PE_ST_ACC; every other code clears the accumulator.
  localparam logic [2:0] PE_ST_CLEAR = 3'd0;
  localparam logic [2:0] PE_ST_ACC   = 3'd1;

  localparam int DEFAULT_DW = 8;

endpackage

// File: rtl/lane_delay.sv
// ---------------------------------------------------------------------------
// lane_delay
// Zero-reset shift register of DEPTH stages used to skew one operand lane
// on its way into the array. A synchronous clear flushes every stage.
// Ports:
//   clk  in   clock
//   rst  in   asynchronous active-high reset (all stages to 0)
//   clr  in   synchronous clear of all stages
//   d_i  in   DW  lane input, shifted in every cycle
//   q_o  out  DW  lane output, DEPTH cycles after d_i
// ---------------------------------------------------------------------------
module lane_delay #(
  parameter int DW    = 8,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  logic [DW-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
    end else if (clr) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) stage_q[k] <= stage_q[k-1];
      stage_q[0] <= d_i;
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// ---------------------------------------------------------------------------
// systolic_feeder
// Upstream sequencer for an NxN MAC array. Accepts k_len operand beats
// (one A column, one B row per beat), pushes them through per-lane delay
// lines onto the array edges, drains the array, then holds the results
// (result_valid) until the collector acknowledges with result_ready.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, k_len        job request (IDLE only) and beat count 1..K_MAX
//   in_valid/in_ready   operand beat handshake; in_a / in_b lanes of DW bits
//   a_row_out/b_col_out skewed operands to the array edges
//   pe_state            PE broadcast: PE_ST_ACC in FEED/DRAIN/WAIT, else clear
//   result_valid/ready  array results final / captured by collector
//   busy, done          FSM not idle / 1-cycle pulse in CLEAR
//   cfg_err             1-cycle pulse after a start with an illegal k_len
// ---------------------------------------------------------------------------
module systolic_feeder
  import tpu_pkg::*;
#(
  parameter int N     = 4,
  parameter int DW    = DEFAULT_DW,
  parameter int K_MAX = 16,
  parameter int SKEW  = 0,
  localparam int CW   = $clog2(K_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] k_len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N*DW-1:0] in_a,
  input  logic [N*DW-1:0] in_b,
  output logic [N*DW-1:0] a_row_out,
  output logic [N*DW-1:0] b_col_out,
  output logic [2:0]    pe_state,
  output logic          result_valid,
  input  logic          result_ready,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  // Cycles needed after the last beat for the slowest lane to reach the
  // far corner of the array.
  localparam int D_LEN = 1 + SKEW * (2 * N - 2);
  localparam int DCW   = $clog2(D_LEN + 1);

  fsm_t           state_q, state_d;
  logic [CW-1:0]  klen_q, klen_d;
  logic [CW-1:0]  beat_q, beat_d;
  logic [DCW-1:0] drain_q, drain_d;
  logic           cfg_err_q, cfg_err_d;

  logic           accept;
  logic           klen_ok;
  logic [CW-1:0]  beat_inc;
  logic           lane_clr;
  logic [N*DW-1:0] a_push;
  logic [N*DW-1:0] b_push;

  assign accept   = (state_q == FEED) && in_valid;
  assign klen_ok  = (k_len != '0) && (k_len <= CW'(K_MAX));
  // Cannot wrap: beat_q stays below klen_q, which is at most K_MAX.
  assign beat_inc = beat_q + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      klen_q    <= '0;
      beat_q    <= '0;
      drain_q   <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      klen_q    <= klen_d;
      beat_q    <= beat_d;
      drain_q   <= drain_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    klen_d    = klen_q;
    beat_d    = beat_q;
    drain_d   = drain_q;
    cfg_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (klen_ok) begin
            klen_d  = k_len;
            beat_d  = '0;
            state_d = FEED;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      FEED: begin
        if (accept) begin
          beat_d = beat_inc;
          if (beat_inc == klen_q) begin
            drain_d = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drain_q == DCW'(D_LEN - 1)) state_d = WAIT;
        else                            drain_d = drain_q + DCW'(1);
      end
      WAIT: begin
        if (result_ready) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bubbles and non-FEED cycles push zeros so the array sums are unaffected.
  assign a_push   = accept ? in_a : '0;
  assign b_push   = accept ? in_b : '0;
  // Flush the delay lines on the way back to IDLE.
  assign lane_clr = (state_q == CLEAR);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      lane_delay #(
        .DW    (DW),
        .DEPTH (1 + SKEW * gi)
      ) u_a_delay (
        .clk (clk),
        .rst (rst),
        .clr (lane_clr),
        .d_i (a_push[gi*DW +: DW]),
        .q_o (a_row_out[gi*DW +: DW])
      );
      lane_delay #(
        .DW    (DW),
        .DEPTH (1 + SKEW * gi)
      ) u_b_delay (
        .clk (clk),
        .rst (rst),
        .clr (lane_clr),
        .d_i (b_push[gi*DW +: DW]),
        .q_o (b_col_out[gi*DW +: DW])
      );
    end
  endgenerate

  // Pure decodes of the state register so the broadcast cannot glitch.
  assign in_ready     = (state_q == FEED);
  assign result_valid = (state_q == WAIT);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == CLEAR);
  assign pe_state     = ((state_q == FEED) || (state_q == DRAIN) || (state_q == WAIT))
                        ? PE_ST_ACC : PE_ST_CLEAR;
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int K_MAX = 16;
  localparam int CW    = $clog2(K_MAX + 1);

  typedef int mat_t [N*N];
  typedef struct {
    int              cyc;
    logic [N*DW-1:0] a;
    logic [N*DW-1:0] b;
  } beat_t;
  typedef struct {
    int            cyc;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } lane_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  // SKEW=0 instance
  logic            start0 = 0, in_valid0 = 0, result_ready0 = 0;
  logic [CW-1:0]   k_len0 = '0;
  logic [N*DW-1:0] in_a0 = '0, in_b0 = '0;
  logic            in_ready0, result_valid0, busy0, done0, cfg_err0;
  logic [N*DW-1:0] a_row0, b_col0;
  logic [2:0]      pe_state0;

  // SKEW=1 instance
  logic            start1 = 0, in_valid1 = 0, result_ready1 = 0;
  logic [CW-1:0]   k_len1 = '0;
  logic [N*DW-1:0] in_a1 = '0, in_b1 = '0;
  logic            in_ready1, result_valid1, busy1, done1, cfg_err1;
  logic [N*DW-1:0] a_row1, b_col1;
  logic [2:0]      pe_state1;

  systolic_feeder #(.N(N), .DW(DW), .K_MAX(K_MAX), .SKEW(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .k_len(k_len0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_a(in_a0), .in_b(in_b0),
    .a_row_out(a_row0), .b_col_out(b_col0), .pe_state(pe_state0),
    .result_valid(result_valid0), .result_ready(result_ready0),
    .busy(busy0), .done(done0), .cfg_err(cfg_err0));

  systolic_feeder #(.N(N), .DW(DW), .K_MAX(K_MAX), .SKEW(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .k_len(k_len1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1),
    .a_row_out(a_row1), .b_col_out(b_col1), .pe_state(pe_state1),
    .result_valid(result_valid1), .result_ready(result_ready1),
    .busy(busy1), .done(done1), .cfg_err(cfg_err1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t bq0[$];
  mat_t  cq0[$];
  lane_t lq1[N][$];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor for the SKEW=0 instance: operand beats and a behavioural MAC array.
  initial begin
    int    accm [N][N];
    beat_t e;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) accm[i][j] = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (a_row0 != '0 || b_col0 != '0) begin
          if (bq0.size() == 0) begin
            total++; bad++;
            $display("FAIL beat0_unexpected: got a=%h b=%h expected no beat (cycle %0d)", a_row0, b_col0, cyc);
          end else begin
            e = bq0.pop_front();
            chk("beat0_a", a_row0, e.a);
            chk("beat0_b", b_col0, e.b);
            chk("beat0_cycle", cyc, e.cyc);
          end
        end
        if (result_valid0) begin
          if (cq0.size() == 0) begin
            total++; bad++;
            $display("FAIL result0_unexpected: got result_valid=1 expected 0 (cycle %0d)", cyc);
          end else begin
            for (int i = 0; i < N; i++)
              for (int j = 0; j < N; j++)
                chk($sformatf("c0[%0d][%0d]", i, j), accm[i][j], cq0[0][i*N+j]);
          end
        end
        if (done0 && cq0.size() > 0) void'(cq0.pop_front());
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            if (pe_state0 == 3'd1)
              accm[i][j] += int'(a_row0[i*DW +: DW]) * int'(b_col0[j*DW +: DW]);
            else
              accm[i][j] = 0;
      end else begin
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) accm[i][j] = 0;
      end
    end
  end

  // Monitor for the SKEW=1 instance: per-lane arrival time and value.
  initial begin
    lane_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < N; i++) begin
          if (a_row1[i*DW +: DW] != '0 || b_col1[i*DW +: DW] != '0) begin
            if (lq1[i].size() == 0) begin
              total++; bad++;
              $display("FAIL lane1_unexpected: lane %0d got a=%0d expected no data (cycle %0d)",
                       i, a_row1[i*DW +: DW], cyc);
            end else begin
              e = lq1[i].pop_front();
              chk($sformatf("lane1_%0d_a", i), a_row1[i*DW +: DW], e.a);
              chk($sformatf("lane1_%0d_b", i), b_col1[i*DW +: DW], e.b);
              chk($sformatf("lane1_%0d_cycle", i), cyc, e.cyc);
            end
          end
        end
      end
    end
  end

  // One job on the SKEW=0 instance.
  task automatic job0(input int klen, input int maxgap, input int hold,
                      input bit directed, input bit start_in_feed);
    mat_t  expc;
    beat_t e;
    int    gap;
    for (int i = 0; i < N*N; i++) expc[i] = 0;
    @(negedge clk);
    chk("idle_busy0", busy0, 0);
    start0 = 1; k_len0 = CW'(klen);
    @(negedge clk);
    start0 = 0;
    chk("feed_ready0", in_ready0, 1);
    chk("feed_pe0", pe_state0, 1);
    chk("legal_cfg_err0", cfg_err0, 0);
    if (start_in_feed) begin start0 = 1; k_len0 = CW'(2); end
    for (int bt = 0; bt < klen; bt++) begin
      gap = (bt == 0) ? 0 : $urandom_range(0, maxgap);
      for (int g = 0; g < gap; g++) begin
        in_valid0 = 0;
        in_a0 = N*DW'($urandom); in_b0 = N*DW'($urandom);
        @(negedge clk);
        chk("gap_ready0", in_ready0, 1);
      end
      in_valid0 = 1;
      for (int i = 0; i < N; i++) begin
        in_a0[i*DW +: DW] = directed ? DW'(i + 1) : DW'($urandom_range(1, 255));
        in_b0[i*DW +: DW] = directed ? DW'(1)     : DW'($urandom_range(1, 255));
      end
      e.cyc = cyc + 1; e.a = in_a0; e.b = in_b0;
      bq0.push_back(e);
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          expc[i*N+j] += int'(in_a0[i*DW +: DW]) * int'(in_b0[j*DW +: DW]);
      @(negedge clk);
      if (bt < klen - 1) chk("feed_ready0", in_ready0, 1);
    end
    cq0.push_back(expc);
    start0 = 0;
    // in_valid kept high with junk through DRAIN/WAIT: must be ignored.
    in_valid0 = 1; in_a0 = '1; in_b0 = '1;
    chk("drain_ready0", in_ready0, 0);
    chk("drain_rv0", result_valid0, 0);
    chk("drain_pe0", pe_state0, 1);
    chk("drain_busy0", busy0, 1);
    @(negedge clk);
    chk("wait_rv0", result_valid0, 1);
    chk("wait_pe0", pe_state0, 1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_rv0", result_valid0, 1);
      chk("hold_pe0", pe_state0, 1);
    end
    in_valid0 = 0;
    result_ready0 = 1;
    @(negedge clk);
    result_ready0 = 0;
    chk("clear_done0", done0, 1);
    chk("clear_pe0", pe_state0, 0);
    chk("clear_rv0", result_valid0, 0);
    chk("clear_busy0", busy0, 1);
    @(negedge clk);
    chk("idle_done0", done0, 0);
    chk("idle_busy0", busy0, 0);
  endtask

  // One job on the SKEW=1 instance: a=5 on every lane, random B.
  task automatic job1(input int klen);
    lane_t e;
    @(negedge clk);
    start1 = 1; k_len1 = CW'(klen);
    @(negedge clk);
    start1 = 0;
    chk("feed_ready1", in_ready1, 1);
    for (int bt = 0; bt < klen; bt++) begin
      in_valid1 = 1;
      for (int i = 0; i < N; i++) begin
        in_a1[i*DW +: DW] = DW'(5);
        in_b1[i*DW +: DW] = DW'($urandom_range(1, 255));
        e.cyc = cyc + 1 + i; e.a = DW'(5); e.b = in_b1[i*DW +: DW];
        lq1[i].push_back(e);
      end
      @(negedge clk);
    end
    in_valid1 = 0;
    for (int d = 0; d < 2*N - 1; d++) begin
      chk("drain_ready1", in_ready1, 0);
      chk("drain_rv1", result_valid1, 0);
      chk("drain_pe1", pe_state1, 1);
      @(negedge clk);
    end
    chk("wait_rv1", result_valid1, 1);
    result_ready1 = 1;
    @(negedge clk);
    result_ready1 = 0;
    chk("clear_done1", done1, 1);
    chk("clear_pe1", pe_state1, 0);
    @(negedge clk);
    chk("idle_busy1", busy1, 0);
  endtask

  task automatic bad_start0(input int klen);
    @(negedge clk);
    start0 = 1; k_len0 = CW'(klen);
    @(negedge clk);
    start0 = 0;
    chk("cfg_err_pulse0", cfg_err0, 1);
    chk("cfg_err_busy0", busy0, 0);
    @(negedge clk);
    chk("cfg_err_end0", cfg_err0, 0);
    chk("cfg_err_idle0", busy0, 0);
  endtask

  task automatic check_zero_outputs0(input string tag);
    chk({tag, "_a_row0"}, a_row0, 0);
    chk({tag, "_b_col0"}, b_col0, 0);
    chk({tag, "_pe0"}, pe_state0, 0);
    chk({tag, "_ready0"}, in_ready0, 0);
    chk({tag, "_rv0"}, result_valid0, 0);
    chk({tag, "_busy0"}, busy0, 0);
    chk({tag, "_done0"}, done0, 0);
    chk({tag, "_cfg_err0"}, cfg_err0, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero_outputs0("reset");
    chk("reset_busy1", busy1, 0);
    chk("reset_a_row1", a_row1, 0);
    rst = 0;

    job0(3, 0, 0, 1, 0);            // directed: c(i,j) = 3*(i+1)
    job0(4, 0, 10, 0, 0);           // long hold in WAIT
    job1(2);                        // skewed lanes, 7-cycle drain
    job0(4, 3, 2, 0, 0);            // bubbles between beats
    bad_start0(0);
    bad_start0(K_MAX + 1);
    job0(3, 1, 1, 0, 1);            // start held during FEED is ignored
    job0(1, 0, 0, 0, 0);
    job0(K_MAX, 1, 0, 0, 0);

    // Abort after 2 of 5 beats.
    @(negedge clk);
    start0 = 1; k_len0 = CW'(5);
    @(negedge clk);
    start0 = 0;
    for (int bt = 0; bt < 2; bt++) begin
      beat_t e;
      in_valid0 = 1;
      for (int i = 0; i < N; i++) begin
        in_a0[i*DW +: DW] = DW'($urandom_range(1, 255));
        in_b0[i*DW +: DW] = DW'($urandom_range(1, 255));
      end
      e.cyc = cyc + 1; e.a = in_a0; e.b = in_b0;
      bq0.push_back(e);
      @(negedge clk);
    end
    in_valid0 = 0;
    #2 rst = 1;
    #1 check_zero_outputs0("abort");
    @(negedge clk);
    rst = 0;
    job0(5, 1, 1, 0, 0);

    for (int r = 0; r < 5; r++)
      job0($urandom_range(1, K_MAX), $urandom_range(0, 2), $urandom_range(0, 3), 0, 0);
    job1(3);

    repeat (2*N + 2) @(negedge clk);
    chk("beats0_left", bq0.size(), 0);
    chk("results0_left", cq0.size(), 0);
    for (int i = 0; i < N; i++) chk("lanes1_left", lq1[i].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
